axi_lite_regcheck_master: RTL and testbench

//  Synthesisable AXI4-Lite master that writes a generated pattern to NUM_REGS slave registers and reads each back.

---
 rtl/axi_lite_regcheck_master.sv | 325 ++++++++++++++++++++++++++++++++
 tb/tb_axi_lite_regcheck_master.sv | 442 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_regcheck_master.sv
// ---------------------------------------------------------------------------
// axi_lite_regcheck_master
//
// AXI4-Lite self-test master. On a start pulse it writes a generated pattern
// to NUM_REGS slave registers and reads each one back, counting readback
// mismatches and non-OKAY responses. Used as a power-on check beside the
// UPAC slave; results are left on the status outputs for software or an ILA.
//
// Ports
//   ACLK, ARESET     clock and synchronous active-high reset
//   start            one-cycle pulse, begins a run when idle (ignored if busy)
//   mode             0 = write/read per register, 1 = all writes then all reads
//   m_axi_aw*        write address channel (prot tied 0)
//   m_axi_w*         write data channel (strobes all ones)
//   m_axi_b*         write response channel
//   m_axi_ar*        read address channel (prot tied 0)
//   m_axi_r*         read data channel
//   busy             run in progress
//   done             one-cycle pulse at the end of a run
//   pass             last run had no errors and no timeout
//   err_count        saturating error count of the last run
//   first_err_addr   address of the first error of the last run (0 if none)
//   timeout          last run was aborted by the handshake watchdog
// ---------------------------------------------------------------------------
module axi_lite_regcheck_master #(
    parameter int unsigned                          C_M_AXI_ADDR_WIDTH = 32,
    parameter int unsigned                          C_M_AXI_DATA_WIDTH = 32,
    parameter int unsigned                          NUM_REGS           = 4,
    parameter logic [C_M_AXI_ADDR_WIDTH-1:0]        BASE_ADDR          = '0,
    parameter int unsigned                          ADDR_STRIDE        = 4,
    parameter logic [C_M_AXI_DATA_WIDTH-1:0]        PATTERN_SEED       = 'h0101FFFF,
    parameter logic [C_M_AXI_DATA_WIDTH-1:0]        PATTERN_INC        = 'h11111111,
    parameter int unsigned                          TIMEOUT_CYCLES     = 1024
) (
    input  logic                              ACLK,
    input  logic                              ARESET,
    input  logic                              start,
    input  logic                              mode,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_awaddr,
    output logic [2:0]                        m_axi_awprot,
    output logic                              m_axi_awvalid,
    input  logic                              m_axi_awready,
    output logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_wdata,
    output logic [C_M_AXI_DATA_WIDTH/8-1:0]   m_axi_wstrb,
    output logic                              m_axi_wvalid,
    input  logic                              m_axi_wready,
    input  logic [1:0]                        m_axi_bresp,
    input  logic                              m_axi_bvalid,
    output logic                              m_axi_bready,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     m_axi_araddr,
    output logic [2:0]                        m_axi_arprot,
    output logic                              m_axi_arvalid,
    input  logic                              m_axi_arready,
    input  logic [C_M_AXI_DATA_WIDTH-1:0]     m_axi_rdata,
    input  logic [1:0]                        m_axi_rresp,
    input  logic                              m_axi_rvalid,
    output logic                              m_axi_rready,
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic [7:0]                        err_count,
    output logic [C_M_AXI_ADDR_WIDTH-1:0]     first_err_addr,
    output logic                              timeout
);

    localparam int unsigned AW = C_M_AXI_ADDR_WIDTH;
    localparam int unsigned DW = C_M_AXI_DATA_WIDTH;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [7:0]  LAST_IDX  = 8'(NUM_REGS - 1);
    localparam logic [TW-1:0] WAIT_MAX = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [AW-1:0] STRIDE  = AW'(ADDR_STRIDE);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        FIN
    } state_t;

    state_t          state;
    logic            mode_r;
    logic [7:0]      idx;
    logic [AW-1:0]   addr_acc;
    logic [DW-1:0]   data_acc;
    logic [TW-1:0]   wait_cnt;

    logic            awvalid_r;
    logic            wvalid_r;
    logic            bready_r;
    logic            arvalid_r;
    logic            rready_r;
    logic            busy_r;
    logic            done_r;
    logic            pass_r;
    logic [7:0]      err_count_r;
    logic [AW-1:0]   first_err_addr_r;
    logic            timeout_r;

    logic aw_hs;
    logic w_hs;
    logic b_hs;
    logic ar_hs;
    logic r_hs;
    logic progress;
    logic beat_err;
    logic is_last;
    logic timed_out;

    assign aw_hs = awvalid_r & m_axi_awready;
    assign w_hs  = wvalid_r  & m_axi_wready;
    assign b_hs  = bready_r  & m_axi_bvalid;
    assign ar_hs = arvalid_r & m_axi_arready;
    assign r_hs  = rready_r  & m_axi_rvalid;

    assign is_last = (idx == LAST_IDX);

    // A handshake on any channel owned by the current state counts as
    // progress and restarts the watchdog.
    always_comb begin
        progress = 1'b0;
        case (state)
            WR_REQ:  progress = aw_hs | w_hs;
            WR_RESP: progress = b_hs;
            RD_REQ:  progress = ar_hs;
            RD_RESP: progress = r_hs;
            default: progress = 1'b0;
        endcase
    end

    // One error per beat: a bad read response and bad data on the same beat
    // still count once.
    always_comb begin
        beat_err = 1'b0;
        if (state == WR_RESP && b_hs && m_axi_bresp != 2'b00) begin
            beat_err = 1'b1;
        end
        if (state == RD_RESP && r_hs &&
            (m_axi_rresp != 2'b00 || m_axi_rdata != data_acc)) begin
            beat_err = 1'b1;
        end
    end

    assign timed_out = (state == WR_REQ || state == WR_RESP ||
                        state == RD_REQ || state == RD_RESP) &&
                       !progress && (wait_cnt == WAIT_MAX);

    // Main sequencer. Address and data come from accumulators stepped once per
    // register, so no multiplier is needed. All interface strobes are
    // registered here and raised on the edge that enters their state.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state            <= IDLE;
            mode_r           <= 1'b0;
            idx              <= '0;
            addr_acc         <= '0;
            data_acc         <= '0;
            wait_cnt         <= '0;
            awvalid_r        <= 1'b0;
            wvalid_r         <= 1'b0;
            bready_r         <= 1'b0;
            arvalid_r        <= 1'b0;
            rready_r         <= 1'b0;
            busy_r           <= 1'b0;
            done_r           <= 1'b0;
            pass_r           <= 1'b0;
            err_count_r      <= '0;
            first_err_addr_r <= '0;
            timeout_r        <= 1'b0;
        end else begin
            done_r <= 1'b0;

            // err_count saturates, so it never returns to zero mid-run and
            // can safely mark the first error.
            if (beat_err) begin
                if (err_count_r != 8'hFF) begin
                    err_count_r <= err_count_r + 8'd1;
                end
                if (err_count_r == 8'd0) begin
                    first_err_addr_r <= addr_acc;
                end
            end

            // Every state change out of an active state coincides with a
            // handshake, so clearing on progress also covers state entry.
            if (progress || state == IDLE || state == FIN) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + TW'(1);
            end

            if (timed_out) begin
                awvalid_r <= 1'b0;
                wvalid_r  <= 1'b0;
                bready_r  <= 1'b0;
                arvalid_r <= 1'b0;
                rready_r  <= 1'b0;
                timeout_r <= 1'b1;
                pass_r    <= 1'b0;
                done_r    <= 1'b1;
                busy_r    <= 1'b0;
                state     <= FIN;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            err_count_r      <= '0;
                            first_err_addr_r <= '0;
                            pass_r           <= 1'b0;
                            timeout_r        <= 1'b0;
                            mode_r           <= mode;
                            idx              <= '0;
                            addr_acc         <= BASE_ADDR;
                            data_acc         <= PATTERN_SEED;
                            awvalid_r        <= 1'b1;
                            wvalid_r         <= 1'b1;
                            busy_r           <= 1'b1;
                            state            <= WR_REQ;
                        end
                    end

                    // AW and W complete independently; a channel whose valid
                    // is already low has finished its handshake.
                    WR_REQ: begin
                        if (aw_hs) begin
                            awvalid_r <= 1'b0;
                        end
                        if (w_hs) begin
                            wvalid_r <= 1'b0;
                        end
                        if ((!awvalid_r || aw_hs) && (!wvalid_r || w_hs)) begin
                            bready_r <= 1'b1;
                            state    <= WR_RESP;
                        end
                    end

                    WR_RESP: begin
                        if (b_hs) begin
                            bready_r <= 1'b0;
                            if (!mode_r) begin
                                arvalid_r <= 1'b1;
                                state     <= RD_REQ;
                            end else if (is_last) begin
                                // Write phase finished: rewind for readback.
                                idx       <= '0;
                                addr_acc  <= BASE_ADDR;
                                data_acc  <= PATTERN_SEED;
                                arvalid_r <= 1'b1;
                                state     <= RD_REQ;
                            end else begin
                                idx       <= idx + 8'd1;
                                addr_acc  <= addr_acc + STRIDE;
                                data_acc  <= data_acc + PATTERN_INC;
                                awvalid_r <= 1'b1;
                                wvalid_r  <= 1'b1;
                                state     <= WR_REQ;
                            end
                        end
                    end

                    RD_REQ: begin
                        if (ar_hs) begin
                            arvalid_r <= 1'b0;
                            rready_r  <= 1'b1;
                            state     <= RD_RESP;
                        end
                    end

                    RD_RESP: begin
                        if (r_hs) begin
                            rready_r <= 1'b0;
                            if (is_last) begin
                                // Include the error from this final beat.
                                pass_r <= (err_count_r == 8'd0) && !beat_err;
                                done_r <= 1'b1;
                                busy_r <= 1'b0;
                                state  <= FIN;
                            end else begin
                                idx      <= idx + 8'd1;
                                addr_acc <= addr_acc + STRIDE;
                                data_acc <= data_acc + PATTERN_INC;
                                if (!mode_r) begin
                                    awvalid_r <= 1'b1;
                                    wvalid_r  <= 1'b1;
                                    state     <= WR_REQ;
                                end else begin
                                    arvalid_r <= 1'b1;
                                    state     <= RD_REQ;
                                end
                            end
                        end
                    end

                    FIN: begin
                        state <= IDLE;
                    end

                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign m_axi_awaddr   = addr_acc;
    assign m_axi_araddr   = addr_acc;
    assign m_axi_wdata    = data_acc;
    assign m_axi_wstrb    = '1;
    assign m_axi_awprot   = 3'b000;
    assign m_axi_arprot   = 3'b000;
    assign m_axi_awvalid  = awvalid_r;
    assign m_axi_wvalid   = wvalid_r;
    assign m_axi_bready   = bready_r;
    assign m_axi_arvalid  = arvalid_r;
    assign m_axi_rready   = rready_r;
    assign busy           = busy_r;
    assign done           = done_r;
    assign pass           = pass_r;
    assign err_count      = err_count_r;
    assign first_err_addr = first_err_addr_r;
    assign timeout        = timeout_r;

endmodule

// File: tb/tb_axi_lite_regcheck_master.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_regcheck_master
//
// Directed bench for axi_lite_regcheck_master with a small RAM slave that can
// add back-pressure, corrupt a readback, return SLVERR or stall AR. Expected
// run results and expected bus events are queued when a run is started and
// compared once the run reports done.
// ---------------------------------------------------------------------------
module tb_axi_lite_regcheck_master;

    localparam int NREGS   = 4;
    localparam int TIMEOUT = 1024;

    typedef struct packed {
        logic        rd;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    typedef struct {
        logic [7:0]  err;
        logic [31:0] first;
        logic        pass;
        logic        tmo;
        int          cycles;
    } run_t;

    logic        ACLK   = 1'b0;
    logic        ARESET = 1'b1;
    logic        start  = 1'b0;
    logic        mode   = 1'b0;

    logic [31:0] m_axi_awaddr;
    logic [2:0]  m_axi_awprot;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp  = 2'b00;
    logic        m_axi_bvalid = 1'b0;
    logic        m_axi_bready;
    logic [31:0] m_axi_araddr;
    logic [2:0]  m_axi_arprot;
    logic        m_axi_arvalid;
    logic        m_axi_arready;
    logic [31:0] m_axi_rdata  = 32'h0;
    logic [1:0]  m_axi_rresp  = 2'b00;
    logic        m_axi_rvalid = 1'b0;
    logic        m_axi_rready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [7:0]  err_count;
    logic [31:0] first_err_addr;
    logic        timeout;

    int checks   = 0;
    int failures = 0;

    // Slave knobs, changed only between runs.
    bit bp_en         = 1'b0;
    bit ar_block      = 1'b0;
    int aw_fix        = -1;
    int w_fix         = -1;
    int corrupt_idx   = -1;
    int bresp_err_idx = -1;
    int rresp_err_idx = -1;

    // Slave internal state.
    logic [31:0] mem [NREGS];
    logic        aw_got = 1'b0;
    logic        w_got  = 1'b0;
    logic [31:0] aw_lat = 32'h0;
    logic [31:0] w_lat  = 32'h0;
    int aw_wait = 0;
    int w_wait  = 0;
    int ar_wait = 0;
    int aw_rnd  = 0;
    int w_rnd   = 0;
    int ar_rnd  = 0;

    ev_t  obs_ev[$];
    ev_t  exp_ev[$];
    run_t run_q[$];
    int   ev_base = 0;

    always #5 ACLK = ~ACLK;

    axi_lite_regcheck_master #(
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .ACLK          (ACLK),
        .ARESET        (ARESET),
        .start         (start),
        .mode          (mode),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awprot  (m_axi_awprot),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arprot  (m_axi_arprot),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rdata   (m_axi_rdata),
        .m_axi_rresp   (m_axi_rresp),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .busy          (busy),
        .done          (done),
        .pass          (pass),
        .err_count     (err_count),
        .first_err_addr(first_err_addr),
        .timeout       (timeout)
    );

    // Ready is either always high or raised after a per-handshake delay of
    // waiting cycles; a fixed delay forces AW-first or W-first ordering.
    assign m_axi_awready = !bp_en ||
        (m_axi_awvalid && aw_wait >= ((aw_fix >= 0) ? aw_fix : aw_rnd));
    assign m_axi_wready  = !bp_en ||
        (m_axi_wvalid && w_wait >= ((w_fix >= 0) ? w_fix : w_rnd));
    assign m_axi_arready = !ar_block &&
        (!bp_en || (m_axi_arvalid && ar_wait >= ar_rnd));

    // RAM slave: responds the cycle after a completed request and logs every
    // committed write and accepted read address.
    always @(posedge ACLK) begin : slave
        logic        aw_now;
        logic        w_now;
        logic        ar_now;
        logic [31:0] a;
        logic [31:0] d;
        ev_t         e;
        aw_now = m_axi_awvalid && m_axi_awready;
        w_now  = m_axi_wvalid && m_axi_wready;
        ar_now = m_axi_arvalid && m_axi_arready;

        if (aw_now) begin
            aw_wait <= 0;
            aw_rnd  <= int'($urandom_range(0, 7));
        end else if (m_axi_awvalid) begin
            aw_wait <= aw_wait + 1;
        end
        if (w_now) begin
            w_wait <= 0;
            w_rnd  <= int'($urandom_range(0, 7));
        end else if (m_axi_wvalid) begin
            w_wait <= w_wait + 1;
        end
        if (ar_now) begin
            ar_wait <= 0;
            ar_rnd  <= int'($urandom_range(0, 7));
        end else if (m_axi_arvalid) begin
            ar_wait <= ar_wait + 1;
        end

        a = aw_got ? aw_lat : m_axi_awaddr;
        d = w_got ? w_lat : m_axi_wdata;
        if (m_axi_bvalid && m_axi_bready) begin
            m_axi_bvalid <= 1'b0;
        end
        if ((aw_got || aw_now) && (w_got || w_now)) begin
            mem[a[3:2]]  <= d;
            m_axi_bvalid <= 1'b1;
            m_axi_bresp  <= (int'(a[3:2]) == bresp_err_idx) ? 2'b10 : 2'b00;
            aw_got       <= 1'b0;
            w_got        <= 1'b0;
            e.rd   = 1'b0;
            e.addr = a;
            e.data = d;
            obs_ev.push_back(e);
        end else begin
            if (aw_now) begin
                aw_got <= 1'b1;
                aw_lat <= m_axi_awaddr;
            end
            if (w_now) begin
                w_got <= 1'b1;
                w_lat <= m_axi_wdata;
            end
        end

        if (m_axi_rvalid && m_axi_rready) begin
            m_axi_rvalid <= 1'b0;
        end
        if (ar_now) begin
            m_axi_rvalid <= 1'b1;
            m_axi_rdata  <= (int'(m_axi_araddr[3:2]) == corrupt_idx) ?
                            32'hDEAD0011 : mem[m_axi_araddr[3:2]];
            m_axi_rresp  <= (int'(m_axi_araddr[3:2]) == rresp_err_idx) ? 2'b10 : 2'b00;
            e.rd   = 1'b1;
            e.addr = m_axi_araddr;
            e.data = 32'h0;
            obs_ev.push_back(e);
        end
    end

    function automatic logic [31:0] patt(input int i);
        return 32'h0101FFFF + 32'(i) * 32'h11111111;
    endfunction

    function automatic ev_t evW(input int i);
        ev_t e;
        e.rd   = 1'b0;
        e.addr = 32'(4 * i);
        e.data = patt(i);
        return e;
    endfunction

    function automatic ev_t evR(input int i);
        ev_t e;
        e.rd   = 1'b1;
        e.addr = 32'(4 * i);
        e.data = 32'h0;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [95:0] obs,
                               input logic [95:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    task automatic pushExpEvents(input logic m);
        if (!m) begin
            for (int i = 0; i < NREGS; i++) begin
                exp_ev.push_back(evW(i));
                exp_ev.push_back(evR(i));
            end
        end else begin
            for (int i = 0; i < NREGS; i++) exp_ev.push_back(evW(i));
            for (int i = 0; i < NREGS; i++) exp_ev.push_back(evR(i));
        end
    endtask

    // Pulses start for one cycle, then flips mode to show it was latched.
    task automatic applyStimulus(input logic m, input logic [7:0] e_err,
                                 input logic [31:0] e_first, input logic e_pass,
                                 input logic e_tmo, input int e_cycles);
        run_t r;
        r.err    = e_err;
        r.first  = e_first;
        r.pass   = e_pass;
        r.tmo    = e_tmo;
        r.cycles = e_cycles;
        run_q.push_back(r);
        ev_base = obs_ev.size();
        mode  = m;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        mode  = ~m;
    endtask

    task automatic waitDone(input int budget, output int cyc);
        bit seen;
        seen = 1'b0;
        cyc  = 0;
        while (!seen && cyc < budget) begin
            tick(1);
            cyc++;
            seen = (done === 1'b1);
        end
        checkOutput("done_seen", 96'(seen), 96'(1));
    endtask

    task automatic checkRun(input int cyc);
        run_t r;
        r = run_q.pop_front();
        if (r.cycles >= 0) checkOutput("run_cycles", 96'(cyc), 96'(r.cycles));
        checkOutput("err_count", 96'(err_count), 96'(r.err));
        checkOutput("first_err_addr", 96'(first_err_addr), 96'(r.first));
        checkOutput("pass", 96'(pass), 96'(r.pass));
        checkOutput("timeout", 96'(timeout), 96'(r.tmo));
        checkOutput("busy_at_done", 96'(busy), 96'(0));
        tick(1);
        checkOutput("done_one_cycle", 96'(done), 96'(0));
    endtask

    task automatic checkEvents();
        int  n;
        ev_t o;
        ev_t e;
        n = exp_ev.size();
        checkOutput("event_count", 96'(obs_ev.size() - ev_base), 96'(n));
        for (int k = 0; k < n; k++) begin
            e = exp_ev.pop_front();
            o = (ev_base + k < obs_ev.size()) ? obs_ev[ev_base + k] : 'x;
            checkOutput($sformatf("event%0d", k), 96'(o), 96'(e));
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_ctrl"},
            96'({m_axi_awvalid, m_axi_wvalid, m_axi_bready, m_axi_arvalid,
                 m_axi_rready, busy, done, pass, timeout, err_count,
                 first_err_addr}), 96'(0));
        checkOutput({tag, "_bus"},
            96'({m_axi_awaddr, m_axi_araddr, m_axi_wdata}), 96'(0));
    endtask

    initial begin : global_watchdog
        #500000;
        $display("[TB] FAIL global_timeout observed=running expected=finished");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin : stim
        int c;
        int dseen;

        // Reset state.
        ARESET = 1'b1;
        tick(3);
        checkAllZero("reset");
        ARESET = 1'b0;
        tick(2);

        // Mode 0, always-ready slave: 4 cycles per register.
        $display("[TB] mode 0 clean run");
        applyStimulus(1'b0, 8'd0, 32'h0, 1'b1, 1'b0, 4 * NREGS);
        pushExpEvents(1'b0);
        checkOutput("busy_after_start", 96'(busy), 96'(1));
        waitDone(100, c);
        checkRun(c);
        checkEvents();

        // Corrupted readback of register 2.
        $display("[TB] corrupted readback");
        corrupt_idx = 2;
        applyStimulus(1'b0, 8'd1, 32'h8, 1'b0, 1'b0, 4 * NREGS);
        pushExpEvents(1'b0);
        waitDone(100, c);
        checkRun(c);
        checkEvents();
        corrupt_idx = -1;

        // Mode 1 with back-pressure: AW first, W first, then random.
        $display("[TB] mode 1 with back-pressure");
        bp_en  = 1'b1;
        aw_fix = 0;
        w_fix  = 5;
        applyStimulus(1'b1, 8'd0, 32'h0, 1'b1, 1'b0, -1);
        pushExpEvents(1'b1);
        waitDone(500, c);
        checkRun(c);
        checkEvents();
        aw_fix = 5;
        w_fix  = 0;
        applyStimulus(1'b1, 8'd0, 32'h0, 1'b1, 1'b0, -1);
        pushExpEvents(1'b1);
        waitDone(500, c);
        checkRun(c);
        checkEvents();
        aw_fix = -1;
        w_fix  = -1;
        applyStimulus(1'b1, 8'd0, 32'h0, 1'b1, 1'b0, -1);
        pushExpEvents(1'b1);
        waitDone(500, c);
        checkRun(c);
        checkEvents();
        bp_en = 1'b0;

        // SLVERR on write of reg 1 and on read of reg 3.
        $display("[TB] error responses");
        bresp_err_idx = 1;
        rresp_err_idx = 3;
        applyStimulus(1'b0, 8'd2, 32'h4, 1'b0, 1'b0, 4 * NREGS);
        pushExpEvents(1'b0);
        waitDone(100, c);
        checkRun(c);
        checkEvents();
        bresp_err_idx = -1;
        rresp_err_idx = -1;

        // AR stalled: watchdog fires after TIMEOUT cycles in RD_REQ.
        $display("[TB] AR stall timeout");
        ar_block = 1'b1;
        applyStimulus(1'b0, 8'd0, 32'h0, 1'b0, 1'b1, 2 + TIMEOUT);
        exp_ev.push_back(evW(0));
        tick(100);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        waitDone(TIMEOUT + 200, c);
        c += 101;
        checkOutput("arvalid_after_timeout", 96'(m_axi_arvalid), 96'(0));
        checkRun(c);
        checkEvents();
        tick(5);
        checkOutput("restart_ignored_busy", 96'(busy), 96'(0));
        checkOutput("timeout_held", 96'(timeout), 96'(1));
        ar_block = 1'b0;

        // Reset during RD_RESP of register 0.
        $display("[TB] reset mid-run");
        mode  = 1'b0;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        checkOutput("in_rd_resp", 96'(m_axi_rready), 96'(1));
        ARESET = 1'b1;
        tick(1);
        checkAllZero("midrun_reset");
        ARESET = 1'b0;
        dseen = 0;
        repeat (20) begin
            tick(1);
            if (done === 1'b1) dseen++;
        end
        checkOutput("no_done_after_reset", 96'(dseen), 96'(0));
        applyStimulus(1'b0, 8'd0, 32'h0, 1'b1, 1'b0, 4 * NREGS);
        pushExpEvents(1'b0);
        waitDone(100, c);
        checkRun(c);
        checkEvents();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
